// File: rtl/hpm_counter_bank_if.sv
// CSR access bundle for hpm_counter_bank: a request/response pair with zero-latency read data.
interface hpm_counter_bank_if #(
    parameter int Xlen = 64
);
    logic            req_i;
    logic            we_i;
    logic [1:0]      sel_i;
    logic [4:0]      idx_i;
    logic [Xlen-1:0] wdata_i;
    logic [Xlen-1:0] rdata_o;
    logic            err_o;

    modport master (
        output req_i, we_i, sel_i, idx_i, wdata_i,
        input  rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, sel_i, idx_i, wdata_i,
        output rdata_o, err_o
    );
endinterface

// File: rtl/hpm_counter_bank.sv
// Bank of hardware performance counters with per-counter event select, edge/level mode and sticky overflow.
// Optional feature macro: HPM_OVERFLOW_IRQ_EN (overflow interrupt and writable ovf_ie bits).
module hpm_counter_bank #(
    parameter int NumCounters  = 6,
    parameter int NumEvents    = 32,
    parameter int CounterWidth = 64,
    parameter int Xlen         = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   debug_mode_i,
    input  logic [NumEvents-1:0]   events_i,
    hpm_counter_bank_if.slave      csr,
    output logic [NumCounters-1:0] ovf_o,
    output logic                   irq_o
);

`ifdef HPM_OVERFLOW_IRQ_EN
    localparam logic [7:0] CfgMask = 8'hFF;
`else
    localparam logic [7:0] CfgMask = 8'h7F;
`endif

    logic [CounterWidth-1:0] r_cnt [NumCounters];
    logic [7:0]              r_cfg [NumCounters];
    logic [NumCounters-1:0]  r_inhibit;
    logic [NumCounters-1:0]  r_ovf;
    logic [NumEvents-1:0]    r_events_q;
    logic                    r_active;

    logic [CounterWidth-1:0] w_cnt_next [NumCounters];
    logic [7:0]              w_cfg_next [NumCounters];
    logic [NumCounters-1:0]  w_ovf_next;
    logic [NumCounters-1:0]  w_inc;
    logic [NumCounters-1:0]  w_wrap;
    logic [NumCounters-1:0]  w_wr_cnt;
    logic [NumCounters-1:0]  w_wr_cfg;
    logic [63:0]             w_ev_now;
    logic [63:0]             w_ev_prev;
    logic [63:0]             w_wdata64;
    logic [63:0]             w_rdata64;
    logic [63:0]             w_rd_cnt;
    logic [7:0]              w_rd_cfg;
    logic                    w_idx_bad;
    logic                    w_err;
    logic                    w_wr;
    logic                    w_wr_inh;
    logic                    w_unused;

    // Events widened to 64 so any 6-bit select is in range; unused and index-0 lines read as 0.
    always_comb begin
        w_ev_now                   = '0;
        w_ev_now[NumEvents-1:0]    = events_i;
        w_ev_now[0]                = 1'b0;
        w_ev_prev                  = '0;
        w_ev_prev[NumEvents-1:0]   = r_events_q;
    end

    assign w_wdata64 = 64'(csr.wdata_i);
    assign w_idx_bad = (32'(csr.idx_i) >= 32'(NumCounters)) && (csr.sel_i != 2'd3);
    assign w_err     = csr.req_i && (w_idx_bad || ((Xlen == 64) && (csr.sel_i == 2'd1)));
    // r_active drops the access still pending at the first edge after reset release.
    assign w_wr      = csr.req_i && csr.we_i && !w_err && r_active;
    assign w_wr_inh  = w_wr && (csr.sel_i == 2'd3);

    for (genvar gi = 0; gi < NumCounters; gi++) begin : g_ctr
        logic [5:0]              w_src;
        logic                    w_hit;
        logic                    w_sel_me;
        logic [CounterWidth-1:0] w_wval;

        assign w_src      = r_cfg[gi][5:0];
        assign w_hit      = r_cfg[gi][6] ? (w_ev_now[w_src] & ~w_ev_prev[w_src]) : w_ev_now[w_src];
        assign w_inc[gi]  = w_hit & ~debug_mode_i & ~r_inhibit[gi];
        assign w_wrap[gi] = w_inc[gi] & (&r_cnt[gi]);
        assign w_sel_me   = (csr.idx_i == 5'(gi));

        assign w_wr_cnt[gi] = w_wr & w_sel_me & ~csr.sel_i[1];
        assign w_wr_cfg[gi] = w_wr & w_sel_me & (csr.sel_i == 2'd2);

        // A 32-bit bus writes one half and leaves the other half of the counter intact.
        always_comb begin
            w_wval = r_cnt[gi];
            if (Xlen == 64) begin
                w_wval = w_wdata64[CounterWidth-1:0];
            end else if (!csr.sel_i[0]) begin
                w_wval[31:0] = w_wdata64[31:0];
            end else begin
                w_wval[CounterWidth-1:32] = w_wdata64[CounterWidth-33:0];
            end
        end

        // The write wins over a same-cycle increment, but a wrap still raises the sticky flag.
        assign w_cnt_next[gi] = w_wr_cnt[gi] ? w_wval
                              : (w_inc[gi] ? (r_cnt[gi] + CounterWidth'(1)) : r_cnt[gi]);
        assign w_cfg_next[gi] = w_wr_cfg[gi] ? (w_wdata64[7:0] & CfgMask) : r_cfg[gi];
        assign w_ovf_next[gi] = w_wrap[gi] | (r_ovf[gi] & ~w_wr_cnt[gi]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NumCounters; k++) begin
                r_cnt[k] <= '0;
                r_cfg[k] <= '0;
            end
            r_inhibit  <= '0;
            r_ovf      <= '0;
            r_events_q <= '0;
            r_active   <= 1'b0;
        end else begin
            for (int k = 0; k < NumCounters; k++) begin
                r_cnt[k] <= w_cnt_next[k];
                r_cfg[k] <= w_cfg_next[k];
            end
            r_ovf      <= w_ovf_next;
            r_events_q <= events_i;
            r_active   <= 1'b1;
            if (w_wr_inh) begin
                r_inhibit <= w_wdata64[NumCounters-1:0];
            end
        end
    end

    always_comb begin
        w_rd_cnt = '0;
        w_rd_cfg = '0;
        for (int k = 0; k < NumCounters; k++) begin
            if (csr.idx_i == 5'(k)) begin
                w_rd_cnt = 64'(r_cnt[k]);
                w_rd_cfg = r_cfg[k];
            end
        end
        case (csr.sel_i)
            2'd0:    w_rdata64 = w_rd_cnt;
            2'd1:    w_rdata64 = {32'd0, w_rd_cnt[63:32]};
            2'd2:    w_rdata64 = 64'(w_rd_cfg);
            default: w_rdata64 = 64'(r_inhibit);
        endcase
        if (!csr.req_i || w_err) begin
            w_rdata64 = '0;
        end
    end

    assign csr.rdata_o = w_rdata64[Xlen-1:0];
    assign csr.err_o   = w_err;
    assign ovf_o       = r_ovf;
    assign w_unused    = ^{w_wdata64, w_rdata64};

`ifdef HPM_OVERFLOW_IRQ_EN
    logic                   r_irq;
    logic [NumCounters-1:0] w_ie;

    for (genvar gi = 0; gi < NumCounters; gi++) begin : g_ie
        assign w_ie[gi] = r_cfg[gi][7];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_ovf & w_ie);
        end
    end

    assign irq_o = r_irq;
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: doc/hpm_counter_bank.md
HPM_COUNTER_BANK -- requirements
Module: hpm_counter_bank

Interface
REQ-001 SHALL have parameter NumCounters, default 6, giving the number of counters (1..29).
REQ-002 SHALL have parameter NumEvents, default 32, giving the number of event inputs (2..64); event 0 never counts.
REQ-003 SHALL have parameter CounterWidth, default 64, giving the counter width (33..64).
REQ-004 SHALL have parameter Xlen, default 64, giving the CSR data width (32 or 64).
REQ-005 SHALL have ports (name  direction  width  meaning), one clock, reset asynchronous active-low:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- debug_mode_i  in  1  freezes all counting while high
- events_i  in  NumEvents  event strobes; bit 0 is ignored
- req_i  in  1  CSR access valid
- we_i  in  1  write (1) or read (0); qualified by req_i
- sel_i  in  2  register kind: 0 counter low, 1 counter high, 2 event config, 3 inhibit
- idx_i  in  5  counter index
- wdata_i  in  Xlen  write data
- rdata_o  out  Xlen  read data, combinational from registered state
- err_o  out  1  illegal access, combinational
- ovf_o  out  NumCounters  sticky overflow flags
- irq_o  out  1  registered overflow interrupt

Function
REQ-006 Each event config register SHALL hold sel[5:0] (event index), mode[6] (0 level, 1 rising edge) and ovf_ie[7]; all other bits read 0.
REQ-007 Level mode: counter i SHALL increment by 1 in every cycle in which events_i[sel] is high.
REQ-008 Edge mode: counter i SHALL increment by 1 in the cycle after events_i[sel] rises.
- The rise is detected against a registered copy of events_i.
REQ-009 A sel value of 0, or a sel value >= NumEvents, SHALL never increment the counter.
REQ-010 A counter SHALL NOT increment while debug_mode_i is high or while its inhibit bit (inhibit register bit i) is set.
REQ-011 A counter at all-ones that increments SHALL wrap to 0 in the same update.
REQ-012 On that wrap the counter's ovf_o bit SHALL set; the bit is sticky.
REQ-013 Reads (req_i=1, we_i=0) SHALL return the current registered value with zero latency.
- sel 0: bits [Xlen-1:0] of the counter, zero-extended above CounterWidth.
- sel 1: bits [63:32] of the counter.
- sel 2: the event config register.
- sel 3: the inhibit register.
REQ-014 Writes SHALL update the target register at the next rising clock edge and be visible to reads in the following cycle.
REQ-015 When a write and an increment target the same counter in the same cycle, the written value SHALL win and the increment SHALL be lost.
REQ-016 A write to a counter's low or high half SHALL clear that counter's ovf_o bit, unless the counter wraps in the same cycle.
REQ-017 err_o SHALL assert for the cycle of the access, with rdata_o=0 and no state change, when:
- req_i=1 and idx_i >= NumCounters with sel != 3; or
- sel=1 with Xlen=64.
REQ-018 When req_i is low, rdata_o SHALL be 0 and err_o SHALL be 0.
REQ-019 Writes with Xlen=32 SHALL affect only the addressed 32-bit half.
- A high-half write SHALL update only bits [CounterWidth-1:32].
REQ-020 Inhibit register bits at positions >= NumCounters SHALL read 0 and ignore writes.

Reset
REQ-021 On rst_ni low, all of the following SHALL be 0, asynchronously: counters, event configs, inhibit register, edge-detect registers, ovf_o and irq_o.
REQ-022 When rst_ni is deasserted in the middle of an access, the block SHALL discard that access.
- Counting resumes at the first rising clock edge with rst_ni high.

Configuration
REQ-023 Macro HPM_OVERFLOW_IRQ_EN defined:
- irq_o SHALL be registered, equal to the OR over i of (ovf_o[i] & ovf_ie_i) from the previous cycle.
- ovf_ie bits SHALL be writable.
REQ-024 Macro HPM_OVERFLOW_IRQ_EN undefined:
- irq_o SHALL be tied to 0.
- ovf_ie SHALL read 0 and ignore writes.
- ovf_o SHALL still operate as specified.

Verification
REQ-025 Level count: config counter 0 with sel=3, mode=0; hold events_i[3] high for 10 cycles -> counter 0 reads 10, while a counter with sel=0 reads 0.
REQ-026 Edge count: counter 1 with sel=5, mode=1; toggle events_i[5] high 2 cycles, low 2 cycles, four times -> counter reads 4.
REQ-027 Wrap and interrupt (HPM_OVERFLOW_IRQ_EN defined, ovf_ie=1):
- Write counter 2 to all-ones, pulse its event once.
- Expect counter = 0 and ovf_o[2]=1, then irq_o=1 one cycle later.
- Write counter 2 = 5 -> ovf_o[2]=0.
REQ-028 Collision: write counter 0 = 100 in a cycle where its event is high -> next read returns 100.
REQ-029 Freeze: set inhibit bit 1, then raise debug_mode_i with events active for 20 cycles -> counters 0 and 1 unchanged; after release only counter 1 stays frozen.
REQ-030 Illegal access: with Xlen=64, read sel=1 -> err_o=1, rdata_o=0; write with idx_i=NumCounters -> err_o=1 and no register changes.
